rsa_timing_probe: RTL and testbench
===================================

# rsa_timing_probe

Downstream observer for the 16-bit RSA decryptor. It watches the decryptor's `start`/`finish` handshake and measures the start-to-finish latency of every decryption in clock cycles. It tags each measurement with the ciphertext and the decrypted result, and queues the records in a small FIFO for a valid/ready reader. It is the measurement front end of the timing side-channel experiment: it never drives the decryptor, and the reader sees only the records it produces.

## Interface
Parameters:
- `CNT_W`, 32: cycle counter / record latency width.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DATA_W`, 16: width of ciphertext tag and plaintext fields.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  copy of the decryptor start pulse.
- `c`  in  DATA_W  ciphertext, sampled when `start` is accepted.
- `finish`  in  1  decryptor done pulse.
- `m_decrypted`  in  DATA_W  decryptor result, sampled with `finish`.
- `clear`  in  1  synchronous flush of probe state.
- `out_valid`  out  1  record available at the FIFO head.
- `out_ready`  in  1  reader accepts the head record.
- `out_cycles`  out  CNT_W  latency of the head record.
- `out_c`  out  DATA_W  ciphertext tag of the head record.
- `out_m`  out  DATA_W  plaintext of the head record.
- `busy`  out  1  a measurement is in progress.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a record was dropped.
- `drop_cnt`  out  8  saturating count of dropped records.
- `proto_err`  out  1  sticky: handshake violation seen.

## Operation
- FSM has two states: IDLE and MEAS. `busy` = (state == MEAS).
- **IDLE, start=1**: latch `c`, set cnt←0, go to MEAS.
- **IDLE, finish=1**: ignore the pulse and set `proto_err`.
- **MEAS, finish=0**:
  - cnt←cnt+1, saturating at all-ones.
  - start=1 here is ignored and sets `proto_err`.
- **MEAS, finish=1**:
  - Push record {cycles = sat(cnt+1), c tag, `m_decrypted`}.
  - If start=0 in the same cycle, go to IDLE.
  - If start=1 in the same cycle (back-to-back), latch the new `c`, set cnt←0, stay in MEAS. This is not an error.
- Latency definition: the number of rising edges from the edge that samples `start` to the edge that samples `finish`. A finish sampled on the very next edge gives 1.
- FIFO:
  - First-word-fall-through.
  - `out_valid` = (level ≠ 0).
  - Pop when out_valid & out_ready.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Full FIFO with push and no pop: drop the new record, set `overflow`, and increment `drop_cnt` (saturating at 255).
- Full FIFO with push and pop in the same cycle: both occur and level is unchanged.
- Empty FIFO with push: no simultaneous pop is possible, because `out_valid` is low that cycle.
- `clear` has priority over every other input in its cycle:
  - FSM→IDLE, FIFO emptied.
  - `overflow`, `drop_cnt`, `proto_err` cleared.
  - A start/finish in the same cycle is discarded.
- `out_*` data fields are don't-care while `out_valid`=0. The bench checks them only when valid.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, cnt 0, FIFO empty, all outputs 0.
- Reset mid-measurement aborts it and produces no record.
- Push to visibility: a record pushed on edge N shows out_valid=1 with its fields after edge N; visible from cycle N+1.
- Pop: the head advances on the accepting edge, and the next record (if any) is presented in the following cycle.
- `level`, `overflow`, `drop_cnt`, `proto_err` are registered and update on the same edge as the event.
- No combinational path from any input to any output.

## Structure
- Package `rsa_probe_pkg` holds:
  - State encoding (IDLE=0, MEAS=1).
  - Default widths.
  - Record layout constant (CNT_W+2·DATA_W bits).
- Sub-module `rsa_probe_fifo`: parameterised synchronous FIFO (width, depth) with push/pop, full/empty, level, FWFT head.
- Top `rsa_timing_probe` holds the FSM, counter, tag latches, sticky flags, drop counter and FIFO instance.

## Test plan
- Single decryption: start with c=1394 at edge 1, finish with m_decrypted=89 at edge 38 → one record {cycles=37, c=1394, m=89}, out_valid next cycle, level=1, no flags.
- Back-to-back: finish and start together with new c=100, second finish 5 edges later → records {37,1394,89} then {5,100,·}, in order, proto_err=0.
- Overflow: DEPTH+2 measurements with out_ready=0 → level=DEPTH, overflow=1, drop_cnt=2; draining returns the first DEPTH records in order.
- Full push+pop: FIFO full, out_ready=1 in the finish cycle → level stays DEPTH, overflow stays 0, head advances.
- Protocol errors: finish in IDLE, and start mid-MEAS → proto_err=1, no spurious record, the original measurement completes with the correct count.
- Reset/clear mid-operation: rst_n low during MEAS with 3 queued records → all outputs 0. Repeat the same setup with `clear` → level=0, busy=0, flags 0 the next cycle.

Source files
------------

// File: rtl/rsa_probe_pkg.sv
// Shared constants for the RSA timing probe: FSM encoding, default widths
// and the layout of one latency record {cycles, c tag, plaintext}.
package rsa_probe_pkg;

  // FSM encoding; kept as plain constants so older tools read it unchanged
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

  localparam int CNT_W_DEF  = 32;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W     = 8;

  // Record = latency in the upper bits, then ciphertext tag, then plaintext
  function automatic int rec_width(input int cnt_w, input int data_w);
    return cnt_w + 2 * data_w;
  endfunction

  localparam int REC_W_DEF = rec_width(CNT_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/rsa_probe_fifo.sv
// First-word-fall-through FIFO for probe records. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module rsa_probe_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Status, accepted push/pop, and the head word (zero while empty)
  always_comb begin
    empty     = (r_wr_ptr == r_rd_ptr);
    full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    level     = r_wr_ptr - r_rd_ptr;
    w_do_pop  = pop && !empty && !clr;
    // A full FIFO still takes a push when the head leaves in the same cycle
    w_do_push = push && (!full || w_do_pop) && !clr;
    if (empty) begin
      dout = '0;
    end else begin
      dout = r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer advance with synchronous flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/rsa_timing_probe.sv
// Passive observer of the RSA decryptor start/finish handshake. Measures the
// latency of each decryption, tags it with ciphertext and result, and queues
// the records for a valid/ready reader.
module rsa_timing_probe
  import rsa_probe_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         c,
  input  logic                      finish,
  input  logic [DATA_W-1:0]         m_decrypted,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          out_cycles,
  output logic [DATA_W-1:0]         out_c,
  output logic [DATA_W-1:0]         out_m,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  output logic                      proto_err
);

  localparam int REC_W = rec_width(CNT_W, DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_c;
  logic                    r_overflow;
  logic                    r_proto_err;
  logic [DROP_W-1:0]       r_drop_cnt;

  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_proto_viol;
  logic                    w_full;
  logic                    w_empty;
  logic [REC_W-1:0]        w_push_rec;
  logic [REC_W-1:0]        w_head_rec;
  logic [$clog2(DEPTH):0]  w_level;

  // Saturating count, record assembly and event decode; clear masks all events
  always_comb begin
    if (&r_cnt) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + CNT_ONE;
    end
    w_push       = (r_state == ST_MEAS) && finish && !clear;
    w_pop        = !w_empty && out_ready && !clear;
    w_drop       = w_push && w_full && !w_pop;
    w_proto_viol = !clear && (((r_state == ST_IDLE) && finish) ||
                              ((r_state == ST_MEAS) && !finish && start));
    w_push_rec   = {w_cnt_inc, r_c, m_decrypted};
  end

  // Measurement FSM: counter and ciphertext tag latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_c     <= c;
            r_cnt   <= '0;
            r_state <= ST_MEAS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MEAS: begin
          if (finish) begin
            // Back-to-back start reopens a measurement in the same edge
            if (start) begin
              r_c   <= c;
              r_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky flags and the saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_proto_viol) begin
        r_proto_err <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (!(&r_drop_cnt)) begin
          r_drop_cnt <= r_drop_cnt + DROP_ONE;
        end
      end
    end
  end

  rsa_probe_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_rec),
    .dout  (w_head_rec),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign out_valid  = !w_empty;
  assign out_cycles = w_head_rec[REC_W-1 -: CNT_W];
  assign out_c      = w_head_rec[2*DATA_W-1 -: DATA_W];
  assign out_m      = w_head_rec[DATA_W-1:0];
  assign busy       = (r_state == ST_MEAS);
  assign level      = w_level;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Directed bench for rsa_timing_probe with hand-computed expected records.
module tb_rsa_timing_probe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] c = 16'd0;
  logic        finish = 1'b0;
  logic [15:0] m_decrypted = 16'd0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_cycles;
  logic [15:0] out_c;
  logic [15:0] out_m;
  logic        busy;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        proto_err;

  int total = 0;
  int bad = 0;

  rsa_timing_probe #(.CNT_W(32), .DEPTH(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c), .finish(finish),
    .m_decrypted(m_decrypted), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_cycles(out_cycles), .out_c(out_c),
    .out_m(out_m), .busy(busy), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start sampled on one edge, finish sampled lat edges later
  task automatic meas(input logic [15:0] cv, input int lat, input logic [15:0] mv);
    start = 1'b1; c = cv;
    tick();
    start = 1'b0;
    repeat (lat - 1) tick();
    finish = 1'b1; m_decrypted = mv;
    tick();
    finish = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input int cyc, input int cv, input int mv);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_cyc"}, out_cycles, cyc);
    check_eq({tag, "_c"}, out_c, cv);
    check_eq({tag, "_m"}, out_m, mv);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cycles", out_cycles, 0);
    rst_n = 1'b1;
    tick();

    // single decryption: latency 37
    start = 1'b1; c = 16'd1394;
    tick();
    start = 1'b0;
    check_eq("single_busy", busy, 1);
    repeat (35) tick();
    check_eq("single_novalid", out_valid, 0);
    tick();
    finish = 1'b1; m_decrypted = 16'd89;
    tick();
    finish = 1'b0;
    check_head("single", 37, 1394, 89);
    check_eq("single_level", level, 1);
    check_eq("single_busy0", busy, 0);
    check_eq("single_ovf", overflow, 0);
    check_eq("single_proto", proto_err, 0);
    pop_one();
    check_eq("single_popped", level, 0);

    // back-to-back: finish and new start on the same edge
    start = 1'b1; c = 16'd1394;
    tick();
    start = 1'b0;
    repeat (36) tick();
    finish = 1'b1; m_decrypted = 16'd89; start = 1'b1; c = 16'd100;
    tick();
    finish = 1'b0; start = 1'b0;
    check_eq("b2b_busy", busy, 1);
    repeat (4) tick();
    finish = 1'b1; m_decrypted = 16'd7;
    tick();
    finish = 1'b0;
    check_eq("b2b_level", level, 2);
    check_eq("b2b_proto", proto_err, 0);
    check_head("b2b_r0", 37, 1394, 89);
    pop_one();
    check_head("b2b_r1", 5, 100, 7);
    pop_one();
    check_eq("b2b_empty", out_valid, 0);

    // overflow: ten records, no reader
    for (int i = 0; i < 10; i++) meas(16'(i * 16 + 3), i + 1, 16'(i + 100));
    check_eq("ovf_level", level, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drop", drop_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("ovf_r%0d", i), i + 1, i * 16 + 3, i + 100);
      pop_one();
    end
    check_eq("ovf_drained", level, 0);
    check_eq("ovf_sticky", overflow, 1);
    do_clear();
    check_eq("ovf_clr_flag", overflow, 0);
    check_eq("ovf_clr_drop", drop_cnt, 0);

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) meas(16'(i), 2, 16'(i + 50));
    check_eq("fpp_full", level, 8);
    start = 1'b1; c = 16'd200;
    tick();
    start = 1'b0;
    finish = 1'b1; m_decrypted = 16'd201; out_ready = 1'b1;
    tick();
    finish = 1'b0; out_ready = 1'b0;
    check_eq("fpp_level", level, 8);
    check_eq("fpp_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      check_head($sformatf("fpp_r%0d", i), 2, i, i + 50);
      pop_one();
    end
    check_head("fpp_last", 1, 200, 201);
    pop_one();
    check_eq("fpp_empty", level, 0);

    // protocol errors: finish in IDLE, start mid-measurement
    finish = 1'b1; m_decrypted = 16'd9;
    tick();
    finish = 1'b0;
    check_eq("pe_idle_flag", proto_err, 1);
    check_eq("pe_idle_norec", level, 0);
    start = 1'b1; c = 16'd55;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; c = 16'd99;
    tick();
    start = 1'b0;
    repeat (3) tick();
    finish = 1'b1; m_decrypted = 16'd5;
    tick();
    finish = 1'b0;
    check_eq("pe_level", level, 1);
    check_head("pe_rec", 7, 55, 5);
    check_eq("pe_flag", proto_err, 1);
    do_clear();

    // reset mid-measurement with three queued records
    for (int i = 0; i < 3; i++) meas(16'(i + 1), 3, 16'(i + 7));
    finish = 1'b1;
    tick();
    finish = 1'b0;
    start = 1'b1; c = 16'd9;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_level", level, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_proto", proto_err, 0);
    check_eq("rst_mid_fields", {out_cycles, out_c, out_m}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_mid_norec", level, 0);

    // same setup, flushed by clear with a finish in the same cycle
    for (int i = 0; i < 3; i++) meas(16'(i + 1), 3, 16'(i + 7));
    finish = 1'b1;
    tick();
    finish = 1'b0;
    start = 1'b1; c = 16'd9;
    tick();
    start = 1'b0;
    check_eq("clr_pre_level", level, 3);
    clear = 1'b1; finish = 1'b1;
    tick();
    clear = 1'b0; finish = 1'b0;
    check_eq("clr_level", level, 0);
    check_eq("clr_busy", busy, 0);
    check_eq("clr_proto", proto_err, 0);
    check_eq("clr_valid", out_valid, 0);
    tick();
    check_eq("clr_norec", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
